sa_wdata_channel: RTL and testbench

//  Slave-side write-data stage of the AXI4 interconnect, directly downstream of the slave-arbiter xADDR stage.

---
 rtl/sa_wdata_channel_pkg.sv | 23 ++
 rtl/sa_wdata_channel_fifo.sv | 48 ++++
 rtl/sa_wdata_channel_skid.sv | 62 ++++++
 rtl/sa_wdata_channel.sv | 109 ++++++++++
 tb/tb_sa_wdata_channel.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sa_wdata_channel_pkg.sv
// Shared definitions for the slave-arbiter address/data channels.
// An order entry is packed as {mst_id, len, crossing}, with mst_id in the MSBs.
package sa_wdata_channel_pkg;
  localparam int MST_AMT_DEF          = 3;
  localparam int OUTSTANDING_AMT_DEF  = 8;
  localparam int DATA_WIDTH_DEF       = 32;
  localparam int TRANS_DATA_LEN_W_DEF = 3;

  // Never returns 0, so a single-master build still gets a usable index width.
  function automatic int mst_id_w(input int mst_amt);
    return (mst_amt > 1) ? $clog2(mst_amt) : 1;
  endfunction

  function automatic int order_entry_w(input int id_w, input int len_w);
    return id_w + len_w + 1;
  endfunction

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_occ_e;
endpackage

// File: rtl/sa_wdata_channel_fifo.sv
// Synchronous FIFO with a look-ahead head: rd_data shows the oldest entry while not empty.
// A push while full is dropped. A push and a pop in the same cycle are both honoured.
module fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic              i_clk,
  input  logic              i_srst,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_full,
  output logic              o_empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_push;
  logic              w_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_push    = i_wr_en & ~o_full;
  assign w_pop     = i_rd_en & ~o_empty;
  assign o_rd_data = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      if (w_push & ~w_pop)      r_count <= r_count + 1'b1;
      else if (~w_push & w_pop) r_count <= r_count - 1'b1;
    end
  end
endmodule

// File: rtl/sa_wdata_channel_skid.sv
// Two-entry skid buffer with registered outputs. Input ready depends on occupancy only,
// so there is never a combinational path from i_ready to o_ready.
module skid_buffer_2e
  import sa_wdata_channel_pkg::*;
#(
  parameter int DATA_W = 33
) (
  input  logic              i_clk,
  input  logic              i_srst,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready
);
  skid_occ_e         r_state;
  logic [DATA_W-1:0] r_out;
  logic [DATA_W-1:0] r_spare;
  logic              w_in_hs;
  logic              w_out_hs;

  assign o_valid  = (r_state != SKID_EMPTY);
  assign o_ready  = (r_state != SKID_FULL);
  assign o_data   = r_out;
  assign w_in_hs  = i_valid & o_ready;
  assign w_out_hs = o_valid & i_ready;

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_state <= SKID_EMPTY;
      r_out   <= '0;
      r_spare <= '0;
    end else begin
      case (r_state)
        SKID_EMPTY: begin
          if (w_in_hs) begin
            r_out   <= i_data;
            r_state <= SKID_ONE;
          end
        end
        SKID_ONE: begin
          if (w_in_hs & w_out_hs) begin
            r_out <= i_data;
          end else if (w_in_hs) begin
            r_spare <= i_data;
            r_state <= SKID_FULL;
          end else if (w_out_hs) begin
            r_state <= SKID_EMPTY;
          end
        end
        SKID_FULL: begin
          if (w_out_hs) begin
            r_out   <= r_spare;
            r_state <= SKID_ONE;
          end
        end
        default: r_state <= SKID_EMPTY;
      endcase
    end
  end
endmodule

// File: rtl/sa_wdata_channel.sv
// Slave-side W stage: replays granted AW order, steers W beats from the owning master,
// regenerates WLAST per segment, and flags master WLAST mismatches.
module sa_wdata_channel
  import sa_wdata_channel_pkg::*;
#(
  parameter int MST_AMT          = MST_AMT_DEF,
  parameter int OUTSTANDING_AMT  = OUTSTANDING_AMT_DEF,
  parameter int MST_ID_W         = mst_id_w(MST_AMT),
  parameter int DATA_WIDTH       = DATA_WIDTH_DEF,
  parameter int TRANS_DATA_LEN_W = TRANS_DATA_LEN_W_DEF
) (
  input  logic                          ACLK_i,
  input  logic                          ARESET_i,
  input  logic [TRANS_DATA_LEN_W-1:0]   xADDR_AxLEN_i,
  input  logic [MST_ID_W-1:0]           xADDR_mst_id_i,
  input  logic                          xADDR_crossing_flag_i,
  input  logic                          xADDR_fifo_order_wr_en_i,
  output logic                          xADDR_stall_o,
  input  logic [DATA_WIDTH*MST_AMT-1:0] dsp_WDATA_i,
  input  logic [MST_AMT-1:0]            dsp_WLAST_i,
  input  logic [MST_AMT-1:0]            dsp_WVALID_i,
  output logic [MST_AMT-1:0]            dsp_WREADY_o,
  output logic [DATA_WIDTH-1:0]         s_WDATA_o,
  output logic                          s_WLAST_o,
  output logic                          s_WVALID_o,
  input  logic                          s_WREADY_i,
  output logic                          wlast_err_o
);
  localparam int ENTRY_W = order_entry_w(MST_ID_W, TRANS_DATA_LEN_W);

  logic [ENTRY_W-1:0]          w_head;
  logic                        w_empty;
  logic [MST_ID_W-1:0]         w_head_id;
  logic [TRANS_DATA_LEN_W-1:0] w_head_len;
  logic                        w_head_cr;
  logic                        w_skid_ready;
  logic                        w_sel_valid;
  logic                        w_sel_wlast;
  logic [DATA_WIDTH-1:0]       w_sel_data;
  logic                        w_beat_hs;
  logic                        w_last;
  logic [TRANS_DATA_LEN_W-1:0] r_beat_cnt;
  logic                        r_err;

  fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (OUTSTANDING_AMT)
  ) u_order_fifo (
    .i_clk     (ACLK_i),
    .i_srst    (ARESET_i),
    .i_wr_en   (xADDR_fifo_order_wr_en_i),
    .i_wr_data ({xADDR_mst_id_i, xADDR_AxLEN_i, xADDR_crossing_flag_i}),
    .i_rd_en   (w_beat_hs & w_last),
    .o_rd_data (w_head),
    .o_full    (xADDR_stall_o),
    .o_empty   (w_empty)
  );

  assign {w_head_id, w_head_len, w_head_cr} = w_head;

  genvar gi;
  generate
    for (gi = 0; gi < MST_AMT; gi++) begin : g_ready
      assign dsp_WREADY_o[gi] = ~w_empty & (w_head_id == MST_ID_W'(gi)) & w_skid_ready;
    end
  endgenerate

  // An out-of-range head id selects nothing, so it can never produce a handshake.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_wlast = 1'b0;
    w_sel_data  = '0;
    for (int i = 0; i < MST_AMT; i++) begin
      if (w_head_id == MST_ID_W'(i)) begin
        w_sel_valid = dsp_WVALID_i[i];
        w_sel_wlast = dsp_WLAST_i[i];
        w_sel_data  = dsp_WDATA_i[DATA_WIDTH*i +: DATA_WIDTH];
      end
    end
  end

  assign w_beat_hs = w_sel_valid & ~w_empty & w_skid_ready;
  assign w_last    = (r_beat_cnt == w_head_len);

  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) begin
      r_beat_cnt <= '0;
      r_err      <= 1'b0;
    end else if (w_beat_hs) begin
      r_beat_cnt <= w_last ? '0 : r_beat_cnt + 1'b1;
      if (w_sel_wlast != (w_last & ~w_head_cr)) r_err <= 1'b1;
    end
  end

  assign wlast_err_o = r_err;

  skid_buffer_2e #(
    .DATA_W (DATA_WIDTH + 1)
  ) u_skid (
    .i_clk   (ACLK_i),
    .i_srst  (ARESET_i),
    .i_data  ({w_last, w_sel_data}),
    .i_valid (w_beat_hs),
    .o_ready (w_skid_ready),
    .o_data  ({s_WLAST_o, s_WDATA_o}),
    .o_valid (s_WVALID_o),
    .i_ready (s_WREADY_i)
  );
endmodule

// File: tb/tb_sa_wdata_channel.sv
// Scoreboard bench: each granted burst queues its expected slave beats in grant order;
// per-master drivers replay their own beat streams and a monitor checks the slave side.
module tb_sa_wdata_channel;
  localparam int M  = 3;
  localparam int DW = 32;
  localparam int LW = 3;
  localparam int IW = 2;

  typedef struct packed {
    logic          l;
    logic [DW-1:0] d;
  } beat_t;

  logic            clk = 1'b0;
  logic            ARESET_i;
  logic [LW-1:0]   xADDR_AxLEN_i;
  logic [IW-1:0]   xADDR_mst_id_i;
  logic            xADDR_crossing_flag_i;
  logic            xADDR_fifo_order_wr_en_i;
  logic            xADDR_stall_o;
  logic [DW*M-1:0] dsp_WDATA_i;
  logic [M-1:0]    dsp_WLAST_i;
  logic [M-1:0]    dsp_WVALID_i;
  logic [M-1:0]    dsp_WREADY_o;
  logic [DW-1:0]   s_WDATA_o;
  logic            s_WLAST_o;
  logic            s_WVALID_o;
  logic            s_WREADY_i;
  logic            wlast_err_o;

  sa_wdata_channel dut (
    .ACLK_i                   (clk),
    .ARESET_i                 (ARESET_i),
    .xADDR_AxLEN_i            (xADDR_AxLEN_i),
    .xADDR_mst_id_i           (xADDR_mst_id_i),
    .xADDR_crossing_flag_i    (xADDR_crossing_flag_i),
    .xADDR_fifo_order_wr_en_i (xADDR_fifo_order_wr_en_i),
    .xADDR_stall_o            (xADDR_stall_o),
    .dsp_WDATA_i              (dsp_WDATA_i),
    .dsp_WLAST_i              (dsp_WLAST_i),
    .dsp_WVALID_i             (dsp_WVALID_i),
    .dsp_WREADY_o             (dsp_WREADY_o),
    .s_WDATA_o                (s_WDATA_o),
    .s_WLAST_o                (s_WLAST_o),
    .s_WVALID_o               (s_WVALID_o),
    .s_WREADY_i               (s_WREADY_i),
    .wlast_err_o              (wlast_err_o)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          n_out = 0;
  int          acc_cnt = 0;
  int          rdy_mode = 1;
  logic [M-1:0] drv_en = '0;
  beat_t       exp_q[$];
  beat_t       mq[M][$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Slave ready: random, forced high, or forced low.
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       s_WREADY_i = ($urandom_range(0, 3) != 0);
        1:       s_WREADY_i = 1'b1;
        default: s_WREADY_i = 1'b0;
      endcase
    end
  end

  // Per-master dispatchers: present the head of each master's beat queue.
  initial begin
    logic [M-1:0] hs;
    forever begin
      @(negedge clk);
      hs = dsp_WVALID_i & dsp_WREADY_o;
      @(posedge clk); #1;
      for (int i = 0; i < M; i++) begin
        if (hs[i] && mq[i].size() > 0) void'(mq[i].pop_front());
        if (drv_en[i] && mq[i].size() > 0 &&
            ((dsp_WVALID_i[i] && !hs[i]) || $urandom_range(0, 3) != 0)) begin
          dsp_WVALID_i[i]         = 1'b1;
          dsp_WDATA_i[DW*i +: DW] = mq[i][0].d;
          dsp_WLAST_i[i]          = mq[i][0].l;
        end else begin
          dsp_WVALID_i[i] = 1'b0;
        end
      end
    end
  end

  // Monitor: scoreboard compare, hold stability under backpressure, one-hot ready.
  initial begin
    logic          have_hold;
    logic [DW-1:0] hold_d;
    logic          hold_l;
    beat_t         e;
    have_hold = 1'b0;
    hold_d    = '0;
    hold_l    = 1'b0;
    forever begin
      @(negedge clk);
      if (ARESET_i) begin
        have_hold = 1'b0;
        continue;
      end
      if (have_hold) begin
        check("hold_valid", s_WVALID_o, 1);
        check("hold_data", s_WDATA_o, hold_d);
        check("hold_last", s_WLAST_o, hold_l);
      end
      have_hold = s_WVALID_o && !s_WREADY_i;
      hold_d    = s_WDATA_o;
      hold_l    = s_WLAST_o;
      if (s_WVALID_o && s_WREADY_i) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got data %0h last %0b, required none", s_WDATA_o, s_WLAST_o);
        end else begin
          e = exp_q.pop_front();
          $display("beat %0d: data=%08h last=%0b", n_out, s_WDATA_o, s_WLAST_o);
          check("s_wdata", s_WDATA_o, e.d);
          check("s_wlast", s_WLAST_o, e.l);
        end
        n_out++;
      end
      if ((dsp_WVALID_i & dsp_WREADY_o) != '0) acc_cnt++;
      check("wready_onehot", $onehot0(dsp_WREADY_o), 1);
    end
  end

  // Model of one granted burst: len+1 beats of fresh data from master m, slave WLAST on the
  // final beat, master WLAST on the final beat unless the segment continues (bad_idx flips one).
  task automatic model_burst(input int m, input int len, input bit cr, input int bad_idx);
    beat_t b;
    for (int k = 0; k <= len; k++) begin
      b.d = $urandom;
      b.l = (k == len) && !cr;
      if (k == bad_idx) b.l = ~b.l;
      mq[m].push_back(b);
      b.l = (k == len);
      exp_q.push_back(b);
    end
  endtask

  task automatic push_raw(input int m, input int len, input bit cr);
    xADDR_mst_id_i           = IW'(m);
    xADDR_AxLEN_i            = LW'(len);
    xADDR_crossing_flag_i    = cr;
    xADDR_fifo_order_wr_en_i = 1'b1;
    @(posedge clk); #1;
    xADDR_fifo_order_wr_en_i = 1'b0;
  endtask

  task automatic push(input int m, input int len, input bit cr, input int bad_idx);
    int t = 0;
    while (xADDR_stall_o && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    check("push_stall_timeout", (t >= 500), 0);
    push_raw(m, len, cr);
    model_burst(m, len, cr, bad_idx);
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || mq[0].size() != 0 || mq[1].size() != 0 ||
            mq[2].size() != 0 || s_WVALID_o) && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_timeout", (t >= 3000), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_s_wvalid"}, s_WVALID_o, 0);
    check({tag, "_s_wdata"}, s_WDATA_o, 0);
    check({tag, "_s_wlast"}, s_WLAST_o, 0);
    check({tag, "_wready"}, dsp_WREADY_o, 0);
    check({tag, "_stall"}, xADDR_stall_o, 0);
    check({tag, "_err"}, wlast_err_o, 0);
  endtask

  initial begin
    int base;
    int t;
    ARESET_i                 = 1'b1;
    xADDR_AxLEN_i            = '0;
    xADDR_mst_id_i           = '0;
    xADDR_crossing_flag_i    = 1'b0;
    xADDR_fifo_order_wr_en_i = 1'b0;
    dsp_WDATA_i              = '0;
    dsp_WLAST_i              = '0;
    dsp_WVALID_i             = '0;
    s_WREADY_i               = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    ARESET_i = 1'b0;
    drv_en   = '1;

    // Single burst, then a 4KB-split pair from one master.
    push(1, 3, 0, -1);
    wait_drain();
    check("t1_err", wlast_err_o, 0);
    check("t1_empty_ready", dsp_WREADY_o, 0);
    push(0, 1, 1, -1);
    push(0, 2, 0, -1);
    wait_drain();
    check("t2_err", wlast_err_o, 0);

    // Master 0 has data ready but master 2 was granted first.
    drv_en = '0;
    push(2, 2, 0, -1);
    push(0, 1, 0, -1);
    drv_en = 3'b001;
    repeat (4) @(posedge clk);
    #1;
    check("t3_m0_blocked", dsp_WREADY_o[0], 0);
    check("t3_no_output", s_WVALID_o, 0);
    drv_en = '1;
    wait_drain();

    // Fill the order FIFO; a ninth push must be dropped.
    drv_en = '0;
    for (int i = 0; i < 8; i++) push(i % M, $urandom_range(0, 3), 0, -1);
    check("t4_stall_full", xADDR_stall_o, 1);
    push_raw(1, 0, 0);
    check("t4_stall_after_9th", xADDR_stall_o, 1);
    drv_en = '1;
    t = 0;
    while (xADDR_stall_o && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    check("t4_stall_release_timeout", (t >= 500), 0);
    wait_drain();
    check("t4_empty_ready", dsp_WREADY_o, 0);

    // Slave backpressure for five cycles mid-burst.
    rdy_mode = 1;
    base = n_out;
    push(0, 7, 0, -1);
    t = 0;
    while (n_out < base + 2 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check("t5_start_timeout", (t >= 200), 0);
    rdy_mode   = 2;
    s_WREADY_i = 1'b0;
    base       = acc_cnt;
    repeat (5) @(posedge clk);
    #1;
    check("t5_absorbed_le2", (acc_cnt - base <= 2), 1);
    rdy_mode = 0;
    wait_drain();
    check("t5_err", wlast_err_o, 0);

    // Early master WLAST sets the sticky error.
    push(2, 3, 0, 1);
    wait_drain();
    check("t6_err_set", wlast_err_o, 1);
    push(1, 0, 0, -1);
    wait_drain();
    check("t6_err_sticky", wlast_err_o, 1);

    // Reset in the middle of a burst discards everything.
    rdy_mode = 1;
    push(1, 7, 0, -1);
    repeat (3) @(posedge clk);
    #1;
    ARESET_i = 1'b1;
    drv_en   = '0;
    for (int i = 0; i < M; i++) mq[i].delete();
    exp_q.delete();
    dsp_WVALID_i = '0;
    @(posedge clk); #1;
    check_idle_outputs("midreset");
    ARESET_i = 1'b0;
    drv_en   = '1;

    // Random traffic with random slave backpressure.
    rdy_mode = 0;
    for (int i = 0; i < 150; i++)
      push($urandom_range(0, M - 1), $urandom_range(0, 7), $urandom_range(0, 1), -1);
    wait_drain();
    check("rand_err", wlast_err_o, 0);
    check("rand_empty_ready", dsp_WREADY_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
